// File: rtl/bk_pkg.sv
// Shared Brent-Kung prefix definitions: widths, (G,P) pair type and dot operator.
package bk_pkg;

   localparam int unsigned BK_WIDTH  = 16;
   localparam int unsigned BK_LEVELS = $clog2(BK_WIDTH);

   // Group generate/propagate pair; g is the MSB of the packed struct.
   typedef struct packed {
      logic g;
      logic p;
   } bk_gp_t;

   // (G,P) o (G',P') = (G | P&G', P&P'); hi covers the more significant span.
   function automatic bk_gp_t bk_dot(input bk_gp_t hi, input bk_gp_t lo);
      bk_gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/bk_up_sweep.sv
// Brent-Kung up-sweep: combines per-bit (g,p) into group terms, level by level.
// Output position i holds the widest group ending at bit i, i.e. the span
// 2^tz(i+1) produced at the highest level that touches that node.
module bk_up_sweep
   import bk_pkg::*;
#(
   parameter int unsigned WIDTH = BK_WIDTH
) (
   input  logic [WIDTH-1:0] p_i,
   input  logic [WIDTH-1:0] g_i,
   output logic [WIDTH-1:0] grp_p_o,
   output logic [WIDTH-1:0] grp_g_o
);

   localparam int unsigned LEVELS = $clog2(WIDTH);

   bk_gp_t [WIDTH-1:0] row;

   // Level l merges node i with node i-2^(l-1) wherever i+1 is a multiple of 2^l.
   // Updated in place: the partner node is never rewritten at the same level.
   always_comb begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
         row[i] = {g_i[i], p_i[i]};
      end
      for (int unsigned l = 1; l <= LEVELS; l++) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (((i + 1) % (32'd1 << l)) == 0) begin
               row[i] = bk_dot(row[i],
                               row[(i >= (32'd1 << (l - 1))) ? i - (32'd1 << (l - 1)) : i]);
            end
         end
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
         grp_g_o[i] = row[i].g;
         grp_p_o[i] = row[i].p;
      end
   end

endmodule

// File: rtl/bk_sub_pipe.sv
// Two-stage Brent-Kung subtractor (a - b - bin) with valid/ready on both sides.
// Stage 1 registers the up-sweep, stage 2 runs the down-sweep, forms the
// difference and flags, and holds them in the output registers.
module bk_sub_pipe
   import bk_pkg::*;
#(
   parameter int unsigned WIDTH = BK_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned LEVELS = $clog2(WIDTH);

   // Handshake state
   logic v1_q, v1_d;
   logic v2_q, v2_d;
   logic s1_load, s2_load;

   // Stage 1 (up-sweep) signals and registers
   logic [WIDTH-1:0] p_d, g_d;
   logic [WIDTH-1:0] grp_p_d, grp_g_d;
   logic [WIDTH-1:0] p_q, grp_p_q, grp_g_q;
   logic             c0_q, am_q, bm_q;

   // Stage 2 (down-sweep) signals and output registers
   bk_gp_t [WIDTH-1:0] pf;
   logic [WIDTH:0]     carry;
   logic [WIDTH-1:0]   diff_d, diff_q;
   logic               bout_d, bout_q;
   logic               zero_d, zero_q;
   logic               neg_d, neg_q;
   logic               ovf_d, ovf_q;

   assign s2_load  = v1_q & (~v2_q | out_ready);
   assign in_ready = ~v1_q | s2_load;
   assign s1_load  = in_valid & in_ready;

   assign v1_d = s1_load | (v1_q & ~s2_load);
   assign v2_d = s2_load | (v2_q & ~out_ready);

   assign p_d = a ^ ~b;
   assign g_d = a & ~b;

   bk_up_sweep #(
      .WIDTH(WIDTH)
   ) u_up_sweep (
      .p_i     (p_d),
      .g_i     (g_d),
      .grp_p_o (grp_p_d),
      .grp_g_o (grp_g_d)
   );

   // Stage-1 capture of bit terms, group terms, carry-in and operand sign bits.
   always_ff @(posedge clk) begin
      if (s1_load) begin
         p_q     <= p_d;
         grp_p_q <= grp_p_d;
         grp_g_q <= grp_g_d;
         c0_q    <= ~bin;
         am_q    <= a[WIDTH-1];
         bm_q    <= b[WIDTH-1];
      end
   end

   // Down-sweep fills in the remaining prefixes, then carries, difference and flags.
   // Node i is resolved at level tz(i+1)+1 from its group term and an
   // already-complete prefix at i-2^(l-1), so an in-place pass is order-safe.
   always_comb begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
         pf[i] = {grp_g_q[i], grp_p_q[i]};
      end
      for (int unsigned k = 1; k < LEVELS; k++) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if ((i >= (32'd1 << (LEVELS - k))) &&
                (((i + 1) % (32'd1 << (LEVELS - k))) == (32'd1 << (LEVELS - k - 1)))) begin
               pf[i] = bk_dot(pf[i], pf[i - (32'd1 << (LEVELS - k - 1))]);
            end
         end
      end
      carry[0] = c0_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         carry[i+1] = pf[i].g | (pf[i].p & c0_q);
      end
      diff_d = p_q ^ carry[WIDTH-1:0];
      bout_d = ~carry[WIDTH];
      zero_d = (diff_d == '0);
      neg_d  = diff_d[WIDTH-1];
      ovf_d  = (am_q ^ bm_q) & (diff_d[WIDTH-1] ^ am_q);
   end

   // Per-stage valid bits; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
      end
   end

   // Output registers load only when stage 2 advances, so a stall holds them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q <= '0;
         bout_q <= 1'b0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (s2_load) begin
         diff_q <= diff_d;
         bout_q <= bout_d;
         zero_q <= zero_d;
         neg_q  <= neg_d;
         ovf_q  <= ovf_d;
      end
   end

   assign diff      = diff_q;
   assign bout      = bout_q;
   assign zero      = zero_q;
   assign neg       = neg_q;
   assign ovf       = ovf_q;
   assign out_valid = v2_q;

endmodule

// File: tb/tb_bk_sub_pipe.sv
// Bench for bk_sub_pipe at WIDTH=16 and WIDTH=8 against an arithmetic reference.
module tb_bk_sub_pipe;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // WIDTH=16 instance
   logic [15:0] a16, b16, d16;
   logic        bin16, iv16, ir16, bo16, z16, n16, ov16, ovld16, or16;
   // WIDTH=8 instance
   logic [7:0]  a8, b8, d8;
   logic        bin8, iv8, ir8, bo8, z8, n8, ov8, ovld8, or8;

   bk_sub_pipe #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .bin(bin16),
      .in_valid(iv16), .in_ready(ir16), .diff(d16), .bout(bo16),
      .zero(z16), .neg(n16), .ovf(ov16), .out_valid(ovld16), .out_ready(or16)
   );

   bk_sub_pipe #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .bin(bin8),
      .in_valid(iv8), .in_ready(ir8), .diff(d8), .bout(bo8),
      .zero(z8), .neg(n8), .ovf(ov8), .out_valid(ovld8), .out_ready(or8)
   );

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   logic [19:0] q16[$];
   logic [19:0] q8[$];
   logic        acc16, pop16_seen;
   logic [15:0] pop16_diff;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference: {diff[15:0], bout, zero, neg, ovf} from plain integer arithmetic.
   function automatic logic [19:0] model(input int w, input logic [15:0] av,
                                         input logic [15:0] bv, input logic cv);
      int full, half, ua, ub, d, sa, sb, sr;
      logic [15:0] dl;
      logic bo, ov;
      full = 1 << w;
      half = full / 2;
      ua = int'(av) % full;
      ub = int'(bv) % full;
      d  = ua - ub - int'(cv);
      bo = (d < 0);
      if (d < 0) d = d + full;
      sa = (ua >= half) ? ua - full : ua;
      sb = (ub >= half) ? ub - full : ub;
      sr = sa - sb - int'(cv);
      ov = (sr < -half) || (sr >= half);
      dl = d[15:0];
      return {dl, bo, (d == 0), (d >= half), ov};
   endfunction

   // One clock: settle, score pops/pushes for both instances, move to next negedge+1.
   task automatic step();
      logic [19:0] e;
      #1;
      acc16      = 1'b0;
      pop16_seen = 1'b0;
      if (ovld16 && or16) begin
         pop16_seen = 1'b1;
         pop16_diff = d16;
         check("sb16_nonempty", 32'(q16.size() != 0), 32'd1);
         if (q16.size() != 0) begin
            e = q16.pop_front();
            check("sb16_result", {12'h000, d16, bo16, z16, n16, ov16}, {12'h000, e});
         end
      end
      if (iv16 && ir16) begin
         acc16 = 1'b1;
         q16.push_back(model(16, a16, b16, bin16));
      end
      if (ovld8 && or8) begin
         check("sb8_nonempty", 32'(q8.size() != 0), 32'd1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            check("sb8_result", {20'h00000, d8, bo8, z8, n8, ov8}, {12'h000, e});
         end
      end
      if (iv8 && ir8) begin
         q8.push_back(model(8, {8'h00, a8}, {8'h00, b8}, bin8));
      end
      @(negedge clk);
      #1;
   endtask

   // Single operand pair through an idle pipe: accepted, absent after one edge,
   // present with the given result after two.
   task automatic single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic [19:0] exp);
      a16 = av; b16 = bv; bin16 = cv; iv16 = 1'b1; or16 = 1'b1;
      step();
      check({tag, "_accept"}, 32'(acc16), 32'd1);
      iv16 = 1'b0;
      check({tag, "_valid_early"}, 32'(ovld16), 32'd0);
      step();
      check({tag, "_valid"}, 32'(ovld16), 32'd1);
      check({tag, "_result"}, {12'h000, d16, bo16, z16, n16, ov16}, {12'h000, exp});
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] exp_seq [3];
      logic [15:0] corner [4];
      int npop;

      exp_seq = '{16'h000F, 16'h001E, 16'h002D};
      corner  = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

      rst_n = 1'b0;
      a16 = '0; b16 = '0; bin16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
      a8  = '0; b8  = '0; bin8  = 1'b0; iv8  = 1'b0; or8  = 1'b1;
      repeat (2) @(negedge clk);
      #1;

      // Reset state
      check("rst_out_valid16", 32'(ovld16), 32'd0);
      check("rst_outputs16", {12'h000, d16, bo16, z16, n16, ov16}, 32'd0);
      check("rst_in_ready16", 32'(ir16), 32'd1);
      check("rst_out_valid8", 32'(ovld8), 32'd0);
      rst_n = 1'b1;

      // Directed arithmetic cases: {diff, bout, zero, neg, ovf}
      single("basic",     16'h1234, 16'h0234, 1'b0, {16'h1000, 4'b0000});
      single("underflow", 16'h0000, 16'h0001, 1'b0, {16'hFFFF, 4'b1010});
      single("sovf",      16'h8000, 16'h0001, 1'b0, {16'h7FFF, 4'b0001});
      single("bin_zero",  16'h0005, 16'h0004, 1'b1, {16'h0000, 4'b0100});

      // Backpressure: three back-to-back operands, consumer stalled for three cycles
      or16 = 1'b0; iv16 = 1'b1; bin16 = 1'b0;
      a16 = 16'h0010; b16 = 16'h0001;
      step();
      check("bp_accept1", 32'(acc16), 32'd1);
      a16 = 16'h0020; b16 = 16'h0002;
      step();
      check("bp_accept2", 32'(acc16), 32'd1);
      check("bp_in_ready_low", 32'(ir16), 32'd0);
      check("bp_valid", 32'(ovld16), 32'd1);
      check("bp_diff_first", 32'(d16), 32'h000F);
      a16 = 16'h0030; b16 = 16'h0003;
      step();
      check("bp_blocked", 32'(acc16), 32'd0);
      check("bp_diff_hold", 32'(d16), 32'h000F);
      check("bp_valid_hold", 32'(ovld16), 32'd1);
      or16 = 1'b1;
      npop = 0;
      for (int c = 0; c < 10 && npop < 3; c++) begin
         step();
         if (acc16) iv16 = 1'b0;
         if (pop16_seen) begin
            check("bp_order", 32'(pop16_diff), 32'(exp_seq[npop]));
            npop++;
         end
      end
      check("bp_count", 32'(npop), 32'd3);
      iv16 = 1'b0;

      // Reset with both stages occupied
      or16 = 1'b0; iv16 = 1'b1;
      a16 = 16'h0100; b16 = 16'h0001;
      step();
      a16 = 16'h0200; b16 = 16'h0002;
      step();
      iv16 = 1'b0;
      check("rf_full", 32'(ir16), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rf_out_valid", 32'(ovld16), 32'd0);
      check("rf_outputs", {12'h000, d16, bo16, z16, n16, ov16}, 32'd0);
      check("rf_in_ready", 32'(ir16), 32'd1);
      q16.delete();
      q8.delete();
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      single("post_rst", 16'h0042, 16'h0002, 1'b0, {16'h0040, 4'b0000});

      // Random soak on both widths with random backpressure
      for (int n = 0; n < 10000; n++) begin
         a16   = 16'($urandom);
         b16   = 16'($urandom);
         if ($urandom_range(0, 7) == 0) a16 = corner[$urandom_range(0, 3)];
         if ($urandom_range(0, 7) == 0) b16 = corner[$urandom_range(0, 3)];
         bin16 = 1'($urandom);
         iv16  = ($urandom_range(0, 3) != 0);
         or16  = ($urandom_range(0, 3) != 0);
         a8    = 8'($urandom);
         b8    = 8'($urandom);
         bin8  = 1'($urandom);
         iv8   = ($urandom_range(0, 3) != 0);
         or8   = ($urandom_range(0, 3) != 0);
         step();
      end

      // Drain both pipes within a bounded number of cycles
      iv16 = 1'b0; or16 = 1'b1;
      iv8  = 1'b0; or8  = 1'b1;
      for (int c = 0; c < 10 && (q16.size() != 0 || q8.size() != 0); c++) begin
         step();
      end
      check("drain16", 32'(q16.size()), 32'd0);
      check("drain8", 32'(q8.size()), 32'd0);
      check("drain_valid16", 32'(ovld16), 32'd0);
      check("drain_valid8", 32'(ovld8), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
